// File: rtl/move_packer.sv
// move_packer: buffers the legal-move stream in a small FIFO, packs two 16-bit
// moves per 32-bit word and writes them to the result RAM from BASE_ADDR
// upward, closing the list with a zero terminator.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   start                           one-cycle pulse, clears state, begins a run
//   mv_valid/mv_data/mv_last        move stream in (valid/ready)
//   mv_ready                        FIFO has room and a run is collecting
//   ram_waitrequest                 RAM busy; pending write is held
//   ram_address/ram_write/
//   ram_writedata                   result RAM write port
//   move_count                      moves accepted this run (saturating)
//   busy, done, overflow            run status
module move_packer #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 16,
  parameter int unsigned MAX_WORDS  = 128,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mv_valid,
  input  logic [15:0]           mv_data,
  input  logic                  mv_last,
  output logic                  mv_ready,
  input  logic                  ram_waitrequest,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_writedata,
  output logic [8:0]            move_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [16:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_seen_q, last_seen_d;
  logic [15:0]           half_q, half_d;
  logic                  have_half_q, have_half_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic                  term_q, term_d;
  logic                  mv_ready_d, ram_write_d, busy_d, done_d, overflow_d;
  logic [ADDR_WIDTH-1:0] ram_address_d;
  logic [DATA_WIDTH-1:0] ram_writedata_d;
  logic [8:0]            move_count_d;
  logic                  push, pop, write_busy, room;
  logic [16:0]           head;
  logic [ADDR_WIDTH-1:0] wr_addr;

  assign head       = fifo_mem[rd_ptr_q];
  assign write_busy = ram_write & ram_waitrequest;
  // index MAX_WORDS-1 is reserved for the terminator
  assign room       = (word_idx_q < LAST_IDX);
  assign wr_addr    = BASE + word_idx_q;

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {mv_last, mv_data};
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      last_seen_q   <= 1'b0;
      half_q        <= '0;
      have_half_q   <= 1'b0;
      word_idx_q    <= '0;
      term_q        <= 1'b0;
      mv_ready      <= 1'b0;
      ram_write     <= 1'b0;
      ram_address   <= BASE;
      ram_writedata <= '0;
      move_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      last_seen_q   <= last_seen_d;
      half_q        <= half_d;
      have_half_q   <= have_half_d;
      word_idx_q    <= word_idx_d;
      term_q        <= term_d;
      mv_ready      <= mv_ready_d;
      ram_write     <= ram_write_d;
      ram_address   <= ram_address_d;
      ram_writedata <= ram_writedata_d;
      move_count    <= move_count_d;
      busy          <= busy_d;
      done          <= done_d;
      overflow      <= overflow_d;
    end
  end

  // next-state, FIFO, pack and write control
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    cnt_d           = cnt_q;
    last_seen_d     = last_seen_q;
    half_d          = half_q;
    have_half_d     = have_half_q;
    word_idx_d      = word_idx_q;
    term_d          = term_q;
    move_count_d    = move_count;
    done_d          = done;
    overflow_d      = overflow;
    // a completed write drops the strobe unless a new word is loaded below
    ram_write_d     = write_busy;
    ram_address_d   = ram_address;
    ram_writedata_d = ram_writedata;
    push            = 1'b0;
    pop             = 1'b0;

    if (start) begin
      state_d         = S_COLLECT;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      cnt_d           = '0;
      last_seen_d     = 1'b0;
      half_d          = '0;
      have_half_d     = 1'b0;
      word_idx_d      = '0;
      term_d          = 1'b0;
      move_count_d    = '0;
      done_d          = 1'b0;
      overflow_d      = 1'b0;
      ram_write_d     = 1'b0;
      ram_address_d   = BASE;
      ram_writedata_d = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (mv_valid && mv_ready) begin
            push     = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (move_count != 9'h1FF) move_count_d = move_count + 9'd1;
            if (mv_last) last_seen_d = 1'b1;
          end
          if (cnt_q != '0 && !write_busy) begin
            pop      = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (!have_half_q) begin
              if (head[16]) begin
                // odd total: the partial word carries its own zero terminator
                ram_write_d   = 1'b1;
                ram_address_d = wr_addr;
                term_d        = 1'b1;
                state_d       = S_FLUSH;
                if (room) begin
                  ram_writedata_d = DATA_WIDTH'({16'h0000, head[15:0]});
                end else begin
                  ram_writedata_d = '0;
                  overflow_d      = 1'b1;
                end
              end else begin
                half_d      = head[15:0];
                have_half_d = 1'b1;
              end
            end else begin
              have_half_d = 1'b0;
              if (room) begin
                ram_write_d     = 1'b1;
                ram_address_d   = wr_addr;
                ram_writedata_d = DATA_WIDTH'({head[15:0], half_q});
                word_idx_d      = word_idx_q + 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
              if (head[16]) state_d = S_FLUSH;
            end
          end
          cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
        S_FLUSH: begin
          if (ram_write && !ram_waitrequest && term_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (!write_busy && !term_q) begin
            // even total: separate zero word after the last pair
            ram_write_d     = 1'b1;
            ram_address_d   = wr_addr;
            ram_writedata_d = '0;
            term_d          = 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d     = (state_d == S_COLLECT) || (state_d == S_FLUSH);
    mv_ready_d = (state_d == S_COLLECT) && !last_seen_d && (cnt_d != FULL_CNT);
  end

endmodule

// File: tb/tb_move_packer.sv
// Directed bench for move_packer: a default instance plus a MAX_WORDS=4
// instance for the overflow case; sel routes the stream to one of them.
module tb_move_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, mv_valid, mv_last, ram_waitrequest, sel;
  logic [15:0] mv_data;

  logic        start_a, valid_a, ready_a, wr_a, busy_a, done_a, ovf_a;
  logic [12:0] addr_a;
  logic [31:0] data_a;
  logic [8:0]  cnt_a;
  logic        start_b, valid_b, ready_b, wr_b, busy_b, done_b, ovf_b;
  logic [12:0] addr_b;
  logic [31:0] data_b;
  logic [8:0]  cnt_b;
  logic        cur_ready, cur_done;

  assign start_a   = start & ~sel;
  assign valid_a   = mv_valid & ~sel;
  assign start_b   = start & sel;
  assign valid_b   = mv_valid & sel;
  assign cur_ready = sel ? ready_b : ready_a;
  assign cur_done  = sel ? done_b : done_a;

  move_packer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mv_valid(valid_a),
    .mv_data(mv_data), .mv_last(mv_last), .mv_ready(ready_a),
    .ram_waitrequest(ram_waitrequest), .ram_address(addr_a), .ram_write(wr_a),
    .ram_writedata(data_a), .move_count(cnt_a), .busy(busy_a), .done(done_a),
    .overflow(ovf_a)
  );

  move_packer #(.MAX_WORDS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mv_valid(valid_b),
    .mv_data(mv_data), .mv_last(mv_last), .mv_ready(ready_b),
    .ram_waitrequest(ram_waitrequest), .ram_address(addr_b), .ram_write(wr_b),
    .ram_writedata(data_b), .move_count(cnt_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [12:0] ea_q[$];
  logic [31:0] ed_q[$];

  // log writes of the selected instance that complete at the next edge
  always @(negedge clk) begin
    if (!reset) begin
      if (!sel && wr_a && !ram_waitrequest) begin
        wa_q.push_back(addr_a);
        wd_q.push_back(data_a);
      end
      if (sel && wr_b && !ram_waitrequest) begin
        wa_q.push_back(addr_b);
        wd_q.push_back(data_b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int w;
    w        = 0;
    mv_valid = 1'b1;
    mv_data  = d;
    mv_last  = l;
    @(negedge clk);
    while (!cur_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!cur_ready) check("ready_timeout", 32'(cur_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    @(negedge clk);
    while (!cur_done && w < 300) begin
      w++;
      @(negedge clk);
    end
    check("done", 32'(cur_done), 32'd1);
  endtask

  task automatic expect_wr(input logic [12:0] a, input logic [31:0] d);
    ea_q.push_back(a);
    ed_q.push_back(d);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa_q.size()), 32'(ea_q.size()));
    for (int i = 0; i < ea_q.size(); i++) begin
      if (i < wa_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(ea_q[i]));
        check($sformatf("%s_data%0d", tag, i), wd_q[i], ed_q[i]);
      end
    end
    wa_q.delete();
    wd_q.delete();
    ea_q.delete();
    ed_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(ready_a), 32'd0);
    check({tag, "_write"}, 32'(wr_a), 32'd0);
    check({tag, "_busy"},  32'(busy_a), 32'd0);
    check({tag, "_done"},  32'(done_a), 32'd0);
    check({tag, "_ovf"},   32'(ovf_a), 32'd0);
    check({tag, "_cnt"},   32'(cnt_a), 32'd0);
    check({tag, "_addr"},  32'(addr_a), 32'd16);
    check({tag, "_wdata"}, data_a, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b1; start = 1'b0; mv_valid = 1'b0; mv_data = '0; mv_last = 1'b0;
    ram_waitrequest = 1'b0; sel = 1'b0;
    repeat (2) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (2) tick();

    // three moves, odd total
    do_start();
    check("t1_ready_after_start", 32'(ready_a), 32'd1);
    check("t1_busy", 32'(busy_a), 32'd1);
    send(16'h1234, 1'b0);
    send(16'h5678, 1'b0);
    send(16'h9ABC, 1'b1);
    mv_valid = 1'b0; mv_last = 1'b0;
    @(negedge clk);
    check("t1_lat_write", 32'(wr_a), 32'd1);
    check("t1_lat_addr", 32'(addr_a), 32'd16);
    check("t1_lat_data", data_a, 32'h5678_1234);
    wait_done();
    check("t1_count", 32'(cnt_a), 32'd3);
    check("t1_ovf", 32'(ovf_a), 32'd0);
    check("t1_ready_done", 32'(ready_a), 32'd0);
    check("t1_busy_done", 32'(busy_a), 32'd0);
    expect_wr(13'd16, 32'h5678_1234);
    expect_wr(13'd17, 32'h0000_9ABC);
    check_writes("t1");

    // two moves, even total
    do_start();
    send(16'h0111, 1'b0);
    send(16'h0222, 1'b1);
    mv_valid = 1'b0; mv_last = 1'b0;
    wait_done();
    check("t2_count", 32'(cnt_a), 32'd2);
    expect_wr(13'd16, 32'h0222_0111);
    expect_wr(13'd17, 32'h0000_0000);
    check_writes("t2");

    // ten-move burst with a six-cycle waitrequest stall
    do_start();
    fork
      begin
        for (int i = 0; i < 10; i++) send(16'h0A00 + 16'(i), (i == 9));
        mv_valid = 1'b0; mv_last = 1'b0;
      end
      begin
        repeat (2) tick();
        ram_waitrequest = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("t3_stall_ready", 32'(ready_a), 32'd0);
        check("t3_stall_write", 32'(wr_a), 32'd1);
        check("t3_stall_addr", 32'(addr_a), 32'd16);
        check("t3_stall_data", data_a, 32'h0A01_0A00);
        @(posedge clk);
        #1;
        ram_waitrequest = 1'b0;
      end
    join
    wait_done();
    check("t3_count", 32'(cnt_a), 32'd10);
    for (int i = 0; i < 5; i++)
      expect_wr(13'd16 + 13'(i), {16'h0A01 + 16'(2 * i), 16'h0A00 + 16'(2 * i)});
    expect_wr(13'd21, 32'h0);
    check_writes("t3");

    // overflow on the MAX_WORDS=4 instance
    sel = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 9; i++) send(16'h0B00 + 16'(i), (i == 8));
    mv_valid = 1'b0; mv_last = 1'b0;
    wait_done();
    check("t4_ovf", 32'(ovf_b), 32'd1);
    check("t4_count", 32'(cnt_b), 32'd9);
    expect_wr(13'd16, 32'h0B01_0B00);
    expect_wr(13'd17, 32'h0B03_0B02);
    expect_wr(13'd18, 32'h0B05_0B04);
    expect_wr(13'd19, 32'h0);
    check_writes("t4");
    sel = 1'b0;
    tick();

    // abort a stalled run with start, then a fresh two-move run
    ram_waitrequest = 1'b1;
    do_start();
    send(16'h0C00, 1'b0);
    send(16'h0C01, 1'b0);
    send(16'h0C02, 1'b0);
    mv_valid = 1'b0;
    tick();
    check("t5_pending", 32'(wr_a), 32'd1);
    do_start();
    ram_waitrequest = 1'b0;
    check("t5_write_dropped", 32'(wr_a), 32'd0);
    check("t5_count_clr", 32'(cnt_a), 32'd0);
    send(16'h0D00, 1'b0);
    send(16'h0D01, 1'b1);
    mv_valid = 1'b0; mv_last = 1'b0;
    wait_done();
    check("t5_count", 32'(cnt_a), 32'd2);
    expect_wr(13'd16, 32'h0D01_0D00);
    expect_wr(13'd17, 32'h0);
    check_writes("t5");

    // asynchronous reset while a write is held
    ram_waitrequest = 1'b1;
    do_start();
    send(16'h0E00, 1'b0);
    send(16'h0E01, 1'b1);
    mv_valid = 1'b0; mv_last = 1'b0;
    w = 0;
    while (!wr_a && w < 20) begin
      tick();
      w++;
    end
    check("t6_write_before_rst", 32'(wr_a), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("t6_async");
    tick();
    reset = 1'b0;
    ram_waitrequest = 1'b0;
    mv_valid = 1'b1;
    mv_data = 16'h0F00;
    repeat (2) tick();
    mv_valid = 1'b0;
    check("t6_idle_ready", 32'(ready_a), 32'd0);
    check("t6_idle_busy", 32'(busy_a), 32'd0);
    check("t6_idle_count", 32'(cnt_a), 32'd0);
    check_writes("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_packer.md
# move_packer

Downstream stage of the legal move generator inside the `control` Avalon-MM block. Accepts the generator's move stream over a valid/ready handshake, buffers it in a small FIFO, and packs two 16-bit moves per 32-bit word. Writes the words into the control block's result RAM from word address 16 upward, followed by a zero terminator, where host software reads them. Reports the move count, busy/done status and overflow to the control register.

## Interface
- `ADDR_WIDTH`, 13, result RAM word address width
- `DATA_WIDTH`, 32, RAM word width; fixed at 32 (two 16-bit moves)
- `BASE_ADDR`, 16, first result word address
- `MAX_WORDS`, 128, result words available including the terminator slot
- `FIFO_DEPTH`, 4, input FIFO entries (power of two)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle pulse: clear state and begin a new run
- `mv_valid`  in  1  move present on `mv_data`
- `mv_data`  in  16  move: [15:10] from square, [9:4] to square, [3:0] flags
- `mv_last`  in  1  qualifies the final move of a generation
- `mv_ready`  out  1  FIFO has room and state is COLLECT
- `ram_waitrequest`  in  1  RAM port busy (host access has priority); hold the write
- `ram_address`  out  ADDR_WIDTH  write word address
- `ram_write`  out  1  write strobe
- `ram_writedata`  out  32  packed word
- `move_count`  out  9  moves accepted this run, saturating at 511
- `busy`  out  1  state is COLLECT or FLUSH
- `done`  out  1  run complete, terminator written
- `overflow`  out  1  at least one move was dropped for lack of space

## Operation
- States: IDLE, COLLECT, FLUSH, DONE. Reset enters IDLE.
- `start` in any state:
  - flush the FIFO and clear the half-word register, word index, `move_count`, `done` and `overflow`
  - drop any pending write
  - go to COLLECT
- COLLECT:
  - Transfer occurs when `mv_valid & mv_ready` at a rising edge. The move is pushed to the FIFO and `move_count` increments, saturating.
  - A transfer with `mv_last=1` marks the last entry; `mv_ready` drops on the next cycle.
- Pack stage:
  - Pops one FIFO entry per cycle when no write is pending.
  - The first move of a pair goes to `ram_writedata[15:0]`; the second fills [31:16] and issues a write at `BASE_ADDR + word_index`. `word_index` then increments.
- When the last entry is popped, go to FLUSH:
  - Odd total: write the partial word with upper half 16'h0000. That zero half is the terminator.
  - Even total: write 32'h0000_0000 at the next index.
  - Go to DONE after the terminator write is accepted.
- Zero-move run (`mv_last` arrives with no moves): not possible; the generator always sends at least one move. With an empty stream no action is taken until the next `start`.
- Overflow:
  - Data words are limited to indices 0..MAX_WORDS-2.
  - A pair that would land at index MAX_WORDS-1 is discarded; `overflow`=1 and later pairs are discarded too.
  - Moves are still accepted and counted, so the generator never stalls on overflow.
  - The terminator 32'h0 is always written at the first unwritten index (at most MAX_WORDS-1).
- DONE: `done`=1 and `mv_ready`=0 until `start`. `mv_valid` is ignored in IDLE and DONE.

## Timing
- Reset values:
  - `mv_ready`, `ram_write`, `busy`, `done`, `overflow` = 0
  - `move_count` = 0
  - `ram_address` = BASE_ADDR
  - `ram_writedata` = 0
- `mv_ready` is registered.
  - High one cycle after `start`.
  - Low whenever the FIFO holds FIFO_DEPTH entries (counting a pop in the same cycle is not required).
- Latency: with an empty FIFO and no waitrequest, the second move of a pair accepted at edge E produces `ram_write`=1 in the cycle after edge E+1.
- Write handshake:
  - `ram_write`, `ram_address` and `ram_writedata` are held stable while `ram_waitrequest`=1.
  - The write completes at the first edge with `ram_write & ~ram_waitrequest`; the strobe drops the next cycle unless another word is ready.
- Throughput: one move per cycle sustained with no waitrequest.
- `done` rises in the cycle after the terminator write completes.
- `start` coincident with a transfer: `start` wins, and the move is discarded.
- Asynchronous `reset` mid-write drops the write immediately.

## Test plan
- Start, then moves 0x1234, 0x5678, 0x9ABC (last) with no stalls → writes 0x5678_1234 @16 and 0x0000_9ABC @17; `move_count`=3; `done`=1 after the second write.
- Moves 0x0111, 0x0222 (last) → 0x0222_0111 @16, terminator 0x0 @17, `move_count`=2.
- Hold `ram_waitrequest`=1 for 6 cycles during a 10-move burst → FIFO fills and `mv_ready` drops. After release the writes land @16..20 in order with correct pairing, terminator @21, no loss.
- MAX_WORDS=4, 9 moves → data @16..18, `overflow`=1, terminator 0x0 @19, `move_count`=9, nothing written ≥ @20.
- `start` pulse after 3 moves of a run, then 2 new moves → no write from the aborted run reaches RAM; new run writes @16 and terminator @17; `move_count`=2.
- Assert `reset` while `ram_write`=1 → all outputs return to reset values in the same cycle; state IDLE; `mv_ready`=0.
